// File: rtl/ysyx_22050019_axi_burst_sram_if.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_axi_burst_sram_if
// AXI4 bundle between a master and the burst SRAM slave.
//   AW : aw_ready_o / aw_valid_i / aw_addr_i / aw_id_i / aw_len_i / aw_size_i / aw_burst_i
//   W  : w_ready_o / w_valid_i / w_data_i / w_strb_i / w_last_i
//   B  : b_ready_i / b_valid_o / b_id_o / b_resp_o
//   AR : ar_ready_o / ar_valid_i / ar_addr_i / ar_id_i / ar_len_i / ar_size_i / ar_burst_i
//   R  : r_ready_i / r_valid_o / r_id_o / r_resp_o / r_data_o / r_last_o
// The _i/_o suffixes are seen from the slave side.
// ----------------------------------------------------------------------------
interface ysyx_22050019_axi_burst_sram_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic                        axi_aw_ready_o;
    logic                        axi_aw_valid_i;
    logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i;
    logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i;
    logic [7:0]                  axi_aw_len_i;
    logic [2:0]                  axi_aw_size_i;
    logic [1:0]                  axi_aw_burst_i;

    logic                        axi_w_ready_o;
    logic                        axi_w_valid_i;
    logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i;
    logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i;
    logic                        axi_w_last_i;

    logic                        axi_b_ready_i;
    logic                        axi_b_valid_o;
    logic [AXI_ID_WIDTH-1:0]     axi_b_id_o;
    logic [1:0]                  axi_b_resp_o;

    logic                        axi_ar_ready_o;
    logic                        axi_ar_valid_i;
    logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i;
    logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i;
    logic [7:0]                  axi_ar_len_i;
    logic [2:0]                  axi_ar_size_i;
    logic [1:0]                  axi_ar_burst_i;

    logic                        axi_r_ready_i;
    logic                        axi_r_valid_o;
    logic [AXI_ID_WIDTH-1:0]     axi_r_id_o;
    logic [1:0]                  axi_r_resp_o;
    logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o;
    logic                        axi_r_last_o;

    modport slave (
        output axi_aw_ready_o,
        input  axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
        output axi_w_ready_o,
        input  axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
        input  axi_b_ready_i,
        output axi_b_valid_o, axi_b_id_o, axi_b_resp_o,
        output axi_ar_ready_o,
        input  axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i,
        input  axi_r_ready_i,
        output axi_r_valid_o, axi_r_id_o, axi_r_resp_o, axi_r_data_o, axi_r_last_o
    );

    modport master (
        input  axi_aw_ready_o,
        output axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i, axi_aw_size_i, axi_aw_burst_i,
        input  axi_w_ready_o,
        output axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i,
        output axi_b_ready_i,
        input  axi_b_valid_o, axi_b_id_o, axi_b_resp_o,
        input  axi_ar_ready_o,
        output axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i, axi_ar_size_i, axi_ar_burst_i,
        output axi_r_ready_i,
        input  axi_r_valid_o, axi_r_id_o, axi_r_resp_o, axi_r_data_o, axi_r_last_o
    );
endinterface

// File: rtl/ysyx_22050019_axi_burst_sram.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_axi_burst_sram
// AXI4 slave memory with FIXED/INCR/WRAP bursts, one outstanding burst per
// direction and a configurable idle gap before the first read beat.
// Storage is an internal array of 64-bit words indexed by address[IDX_HI:3].
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (drops any in-flight burst)
//   axi  - slave side of ysyx_22050019_axi_burst_sram_if
// Illegal size (>3), reserved burst (11) and WRAP with len not in {1,3,7,15}
// answer SLVERR for every beat; the burst still runs, advancing as INCR.
// ----------------------------------------------------------------------------
module ysyx_22050019_axi_burst_sram #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int RD_LATENCY     = 0,
    parameter int MEM_WORDS_LOG2 = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22050019_axi_burst_sram_if.slave axi
);
    localparam int         IDX_HI   = MEM_WORDS_LOG2 + 2;
    localparam int         STRB_W   = AXI_DATA_WIDTH / 8;
    localparam logic [7:0] LAT_LAST = (RD_LATENCY > 0) ? 8'(RD_LATENCY - 1) : 8'd0;

    typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
    typedef logic [AXI_ID_WIDTH-1:0]   id_t;
    typedef logic [AXI_DATA_WIDTH-1:0] data_t;
    typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    // Reserved bursts and malformed WRAPs fall back to INCR addressing.
    function automatic mode_e burst_mode(input logic [7:0] len, input logic [1:0] burst);
        mode_e m;
        m = MODE_INCR;
        if (burst == 2'b00)                        m = MODE_FIXED;
        else if (burst == 2'b10 && wrap_len_ok(len)) m = MODE_WRAP;
        return m;
    endfunction

    // WRAP: once the incremented address hits the top of the (len+1)<<size
    // window, it folds back to the window base.
    function automatic addr_t next_addr(input addr_t addr, input logic [7:0] len,
                                        input logic [2:0] size, input mode_e mode);
        addr_t incr, mask, nxt;
        incr = addr_t'(1) << size;
        mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        nxt  = addr + incr;
        case (mode)
            MODE_FIXED: nxt = addr;
            MODE_WRAP:  if ((nxt & mask) == '0) nxt = addr & ~mask;
            default:    ;
        endcase
        return nxt;
    endfunction

    // NOTE: storage has no reset; clearing thousands of words costs a wide reset tree and the contents must survive rst anyway.
    data_t mem [2**MEM_WORDS_LOG2];

    // ---------------- write channel ----------------
    wstate_e    wstate_q, wstate_d;
    addr_t      waddr_q, waddr_d;
    id_t        wid_q, wid_d;
    logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0] wsize_q, wsize_d;
    mode_e      wmode_q, wmode_d;
    logic       werr_q, werr_d;
    logic       aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic       w_hs;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
        wstate_d   = wstate_q;
        waddr_d    = waddr_q;
        wid_d      = wid_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wsize_d    = wsize_q;
        wmode_d    = wmode_q;
        werr_d     = werr_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        w_hs       = 1'b0;
        unique case (wstate_q)
            W_IDLE: if (axi.axi_aw_valid_i) begin
                waddr_d    = axi.axi_aw_addr_i;
                wid_d      = axi.axi_aw_id_i;
                wlen_d     = axi.axi_aw_len_i;
                wsize_d    = axi.axi_aw_size_i;
                wmode_d    = burst_mode(axi.axi_aw_len_i, axi.axi_aw_burst_i);
                werr_d     = burst_err(axi.axi_aw_len_i, axi.axi_aw_size_i, axi.axi_aw_burst_i);
                wcnt_d     = 8'd0;
                aw_ready_d = 1'b0;
                w_ready_d  = 1'b1;
                wstate_d   = W_DATA;
            end
            W_DATA: if (axi.axi_w_valid_i) begin
                w_hs = 1'b1;
                if (axi.axi_w_last_i && wcnt_q != wlen_q) werr_d = 1'b1;
                if (wcnt_q == wlen_q) begin
                    w_ready_d = 1'b0;
                    b_valid_d = 1'b1;
                    wstate_d  = W_RESP;
                end else begin
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wmode_q);
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
            W_RESP: if (axi.axi_b_ready_i) begin
                b_valid_d  = 1'b0;
                aw_ready_d = 1'b1;
                wstate_d   = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            wstate_q   <= W_IDLE;
            waddr_q    <= '0;
            wid_q      <= '0;
            wlen_q     <= '0;
            wcnt_q     <= '0;
            wsize_q    <= '0;
            wmode_q    <= MODE_INCR;
            werr_q     <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            waddr_q    <= waddr_d;
            wid_q      <= wid_d;
            wlen_q     <= wlen_d;
            wcnt_q     <= wcnt_d;
            wsize_q    <= wsize_d;
            wmode_q    <= wmode_d;
            werr_q     <= werr_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi.axi_w_strb_i[b]) mem[waddr_q[IDX_HI:3]][8*b +: 8] <= axi.axi_w_data_i[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_e                 rstate_q, rstate_d;
    addr_t                   raddr_q, raddr_d;
    id_t                     rid_q, rid_d;
    logic [7:0]              rlen_q, rlen_d, rcnt_q, rcnt_d, lat_q, lat_d;
    logic [2:0]              rsize_q, rsize_d;
    mode_e                   rmode_q, rmode_d;
    logic                    rerr_q, rerr_d;
    logic                    ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
    data_t                   r_data_q, r_data_d;
    logic                    rd_load;
    logic [MEM_WORDS_LOG2-1:0] rd_idx;

    always_comb begin
        rstate_d   = rstate_q;
        raddr_d    = raddr_q;
        rid_d      = rid_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        lat_d      = lat_q;
        rsize_d    = rsize_q;
        rmode_d    = rmode_q;
        rerr_d     = rerr_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        rd_load    = 1'b0;
        rd_idx     = raddr_q[IDX_HI:3];
        unique case (rstate_q)
            R_IDLE: if (axi.axi_ar_valid_i) begin
                raddr_d    = axi.axi_ar_addr_i;
                rid_d      = axi.axi_ar_id_i;
                rlen_d     = axi.axi_ar_len_i;
                rsize_d    = axi.axi_ar_size_i;
                rmode_d    = burst_mode(axi.axi_ar_len_i, axi.axi_ar_burst_i);
                rerr_d     = burst_err(axi.axi_ar_len_i, axi.axi_ar_size_i, axi.axi_ar_burst_i);
                rcnt_d     = 8'd0;
                lat_d      = 8'd0;
                ar_ready_d = 1'b0;
                if (RD_LATENCY == 0) begin
                    rd_load   = 1'b1;
                    rd_idx    = axi.axi_ar_addr_i[IDX_HI:3];
                    r_valid_d = 1'b1;
                    r_last_d  = (axi.axi_ar_len_i == 8'd0);
                    rstate_d  = R_DATA;
                end else begin
                    rstate_d  = R_WAIT;
                end
            end
            R_WAIT: if (lat_q == LAT_LAST) begin
                rd_load   = 1'b1;
                r_valid_d = 1'b1;
                r_last_d  = (rlen_q == 8'd0);
                rstate_d  = R_DATA;
            end else begin
                lat_d = lat_q + 8'd1;
            end
            R_DATA: if (axi.axi_r_ready_i) begin
                if (r_last_q) begin
                    r_valid_d  = 1'b0;
                    ar_ready_d = 1'b1;
                    rstate_d   = R_IDLE;
                end else begin
                    raddr_d  = next_addr(raddr_q, rlen_q, rsize_q, rmode_q);
                    rd_idx   = raddr_d[IDX_HI:3];
                    rd_load  = 1'b1;
                    rcnt_d   = rcnt_q + 8'd1;
                    r_last_d = (rcnt_q + 8'd1 == rlen_q);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        // Data only moves on a load, so it holds steady through r_ready stalls.
        r_data_d = rd_load ? mem[rd_idx] : r_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q   <= R_IDLE;
            raddr_q    <= '0;
            rid_q      <= '0;
            rlen_q     <= '0;
            rcnt_q     <= '0;
            lat_q      <= '0;
            rsize_q    <= '0;
            rmode_q    <= MODE_INCR;
            rerr_q     <= 1'b0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
        end else begin
            rstate_q   <= rstate_d;
            raddr_q    <= raddr_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            rcnt_q     <= rcnt_d;
            lat_q      <= lat_d;
            rsize_q    <= rsize_d;
            rmode_q    <= rmode_d;
            rerr_q     <= rerr_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_data_q   <= r_data_d;
        end
    end

    assign axi.axi_aw_ready_o = aw_ready_q;
    assign axi.axi_w_ready_o  = w_ready_q;
    assign axi.axi_b_valid_o  = b_valid_q;
    assign axi.axi_b_id_o     = wid_q;
    assign axi.axi_b_resp_o   = {werr_q, 1'b0};
    assign axi.axi_ar_ready_o = ar_ready_q;
    assign axi.axi_r_valid_o  = r_valid_q;
    assign axi.axi_r_id_o     = rid_q;
    assign axi.axi_r_resp_o   = {rerr_q, 1'b0};
    assign axi.axi_r_data_o   = r_data_q;
    assign axi.axi_r_last_o   = r_last_q;
endmodule

// File: tb/tb_ysyx_22050019_axi_burst_sram.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22050019_axi_burst_sram
// Drives two instances (RD_LATENCY 0 and 3) from one master. Writes go to
// both so their memories stay identical; AR goes only to the instance picked
// by sel, whose outputs are the ones observed. Expected data, beat addresses
// and responses come from a word-addressed associative-array model.
// ----------------------------------------------------------------------------
module tb_ysyx_22050019_axi_burst_sram;
    localparam int          BUDGET = 64;
    localparam logic [63:0] BASE   = 64'h8000_0000;

    logic clk;
    logic rst;
    logic sel;
    int   vectors     = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;
    logic [63:0] aw_addr, ar_addr, w_data;
    logic [3:0]  aw_id, ar_id;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst;

    ysyx_22050019_axi_burst_sram_if bus0 ();
    ysyx_22050019_axi_burst_sram_if bus3 ();

    ysyx_22050019_axi_burst_sram #(.RD_LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .axi(bus0));
    ysyx_22050019_axi_burst_sram #(.RD_LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .axi(bus3));

    assign bus0.axi_aw_valid_i = aw_valid;  assign bus3.axi_aw_valid_i = aw_valid;
    assign bus0.axi_aw_addr_i  = aw_addr;   assign bus3.axi_aw_addr_i  = aw_addr;
    assign bus0.axi_aw_id_i    = aw_id;     assign bus3.axi_aw_id_i    = aw_id;
    assign bus0.axi_aw_len_i   = aw_len;    assign bus3.axi_aw_len_i   = aw_len;
    assign bus0.axi_aw_size_i  = aw_size;   assign bus3.axi_aw_size_i  = aw_size;
    assign bus0.axi_aw_burst_i = aw_burst;  assign bus3.axi_aw_burst_i = aw_burst;
    assign bus0.axi_w_valid_i  = w_valid;   assign bus3.axi_w_valid_i  = w_valid;
    assign bus0.axi_w_data_i   = w_data;    assign bus3.axi_w_data_i   = w_data;
    assign bus0.axi_w_strb_i   = w_strb;    assign bus3.axi_w_strb_i   = w_strb;
    assign bus0.axi_w_last_i   = w_last;    assign bus3.axi_w_last_i   = w_last;
    assign bus0.axi_b_ready_i  = b_ready;   assign bus3.axi_b_ready_i  = b_ready;
    assign bus0.axi_ar_valid_i = ar_valid & ~sel;
    assign bus3.axi_ar_valid_i = ar_valid & sel;
    assign bus0.axi_ar_addr_i  = ar_addr;   assign bus3.axi_ar_addr_i  = ar_addr;
    assign bus0.axi_ar_id_i    = ar_id;     assign bus3.axi_ar_id_i    = ar_id;
    assign bus0.axi_ar_len_i   = ar_len;    assign bus3.axi_ar_len_i   = ar_len;
    assign bus0.axi_ar_size_i  = ar_size;   assign bus3.axi_ar_size_i  = ar_size;
    assign bus0.axi_ar_burst_i = ar_burst;  assign bus3.axi_ar_burst_i = ar_burst;
    assign bus0.axi_r_ready_i  = r_ready;   assign bus3.axi_r_ready_i  = r_ready;

    logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o, r_last_o;
    logic [3:0]  b_id_o, r_id_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [63:0] r_data_o;
    assign aw_ready_o = sel ? bus3.axi_aw_ready_o : bus0.axi_aw_ready_o;
    assign w_ready_o  = sel ? bus3.axi_w_ready_o  : bus0.axi_w_ready_o;
    assign b_valid_o  = sel ? bus3.axi_b_valid_o  : bus0.axi_b_valid_o;
    assign b_id_o     = sel ? bus3.axi_b_id_o     : bus0.axi_b_id_o;
    assign b_resp_o   = sel ? bus3.axi_b_resp_o   : bus0.axi_b_resp_o;
    assign ar_ready_o = sel ? bus3.axi_ar_ready_o : bus0.axi_ar_ready_o;
    assign r_valid_o  = sel ? bus3.axi_r_valid_o  : bus0.axi_r_valid_o;
    assign r_id_o     = sel ? bus3.axi_r_id_o     : bus0.axi_r_id_o;
    assign r_resp_o   = sel ? bus3.axi_r_resp_o   : bus0.axi_r_resp_o;
    assign r_data_o   = sel ? bus3.axi_r_data_o   : bus0.axi_r_data_o;
    assign r_last_o   = sel ? bus3.axi_r_last_o   : bus0.axi_r_last_o;

    // ---------------- reference model ----------------
    logic [63:0] model_mem [logic [63:0]];

    function automatic logic [63:0] beat_word(input logic [63:0] start, input int len,
                                              input int size, input int burst, input int i);
        logic [63:0] incr, bnd, base, a;
        incr = 64'd1 << size;
        if (burst == 0) a = start;
        else if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            bnd  = 64'(len + 1) * incr;
            base = start - (start % bnd);
            a    = base + ((start - base) + 64'(i) * incr) % bnd;
        end else a = start + 64'(i) * incr;
        return a & ~64'h7;
    endfunction

    function automatic bit burst_is_err(input int len, input int size, input int burst);
        return size > 3 || burst == 3 ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [63:0] addr, input logic [3:0] id, input int len,
                            input int size, input int burst, input bit rand_strb,
                            input bit early_last, input bit use_fixed,
                            input logic [63:0] fixed_data, input string tag);
        bit err;
        int n;
        logic [63:0] d, word, ba;
        logic [7:0]  s;
        err = burst_is_err(len, size, burst);
        aw_addr = addr; aw_id = id; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst);
        aw_valid = 1'b1;
        n = 0;
        while (!aw_ready_o && n < BUDGET) begin step(); n++; end
        check({tag, ".aw_wait"}, 64'(n), 64'd0);
        step();
        aw_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            d = use_fixed ? fixed_data : {$urandom, $urandom};
            s = rand_strb ? 8'($urandom) : 8'hFF;
            w_data = d; w_strb = s; w_valid = 1'b1;
            w_last = (i == len) || (early_last && i == 0);
            if (w_last && i != len) err = 1'b1;
            n = 0;
            while (!w_ready_o && n < BUDGET) begin step(); n++; end
            check({tag, ".w_wait"}, 64'(n), 64'd0);
            step();
            ba   = beat_word(addr, len, size, burst, i);
            word = model_mem.exists(ba) ? model_mem[ba] : 64'd0;
            for (int b = 0; b < 8; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
            model_mem[ba] = word;
        end
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        n = 0;
        while (!b_valid_o && n < BUDGET) begin step(); n++; end
        check({tag, ".b_lat"}, 64'(n), 64'd0);
        check({tag, ".b_id"}, 64'(b_id_o), 64'(id));
        check({tag, ".b_resp"}, 64'(b_resp_o), err ? 64'd2 : 64'd0);
        step();
        b_ready = 1'b0;
        check({tag, ".b_drop"}, 64'(b_valid_o), 64'd0);
        check({tag, ".aw_ready_back"}, 64'(aw_ready_o), 64'd1);
    endtask

    task automatic rd_burst(input logic [63:0] addr, input logic [3:0] id, input int len,
                            input int size, input int burst, input bit toggle,
                            input int exp_lat, input string tag);
        bit err;
        int n;
        logic [63:0] exp_d;
        err = burst_is_err(len, size, burst);
        ar_addr = addr; ar_id = id; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst);
        ar_valid = 1'b1;
        r_ready  = 1'b1;
        n = 0;
        while (!ar_ready_o && n < BUDGET) begin step(); n++; end
        check({tag, ".ar_wait"}, 64'(n), 64'd0);
        step();
        ar_valid = 1'b0;
        n = 0;
        while (!r_valid_o && n < BUDGET) begin step(); n++; end
        check({tag, ".first_lat"}, 64'(n), 64'(exp_lat));
        for (int i = 0; i <= len; i++) begin
            exp_d = model_mem[beat_word(addr, len, size, burst, i)];
            if (toggle && (i % 2 == 0)) begin
                r_ready = 1'b0;
                step();
                check({tag, ".stall_valid"}, 64'(r_valid_o), 64'd1);
                check({tag, ".stall_data"}, r_data_o, exp_d);
                check({tag, ".stall_last"}, 64'(r_last_o), 64'(i == len));
                r_ready = 1'b1;
            end
            check({tag, ".r_valid"}, 64'(r_valid_o), 64'd1);
            check({tag, ".r_data"}, r_data_o, exp_d);
            check({tag, ".r_last"}, 64'(r_last_o), 64'(i == len));
            check({tag, ".r_resp"}, 64'(r_resp_o), err ? 64'd2 : 64'd0);
            check({tag, ".r_id"}, 64'(r_id_o), 64'(id));
            step();
        end
        check({tag, ".r_drop"}, 64'(r_valid_o), 64'd0);
        check({tag, ".ar_ready_back"}, 64'(ar_ready_o), 64'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [3:0]  id;
        int          len, burst;

        // Reset state
        sel = 1'b0; rst = 1'b1;
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 0;
        repeat (3) step();
        rst = 1'b0;
        check("rst.aw_ready", 64'(aw_ready_o), 64'd1);
        check("rst.ar_ready", 64'(ar_ready_o), 64'd1);
        check("rst.w_ready", 64'(w_ready_o), 64'd0);
        check("rst.b_valid", 64'(b_valid_o), 64'd0);
        check("rst.r_valid", 64'(r_valid_o), 64'd0);
        check("rst.r_last", 64'(r_last_o), 64'd0);
        check("rst.r_data", r_data_o, 64'd0);

        // Fill 32 words so every later read and partial-strobe write hits known data
        wr_burst(BASE, 4'h1, 15, 3, 1, 0, 0, 0, 64'd0, "init0");
        wr_burst(BASE + 64'h80, 4'h2, 15, 3, 1, 0, 0, 0, 64'd0, "init1");

        // Single-beat write then read back
        wr_burst(BASE, 4'hA, 0, 3, 1, 0, 0, 1, 64'h1122_3344_5566_7788, "t1_wr");
        rd_burst(BASE, 4'h5, 0, 3, 1, 0, 0, "t1_rd");

        // INCR and WRAP reads
        rd_burst(BASE + 64'h10, 4'h3, 3, 3, 1, 0, 0, "t2_incr");
        rd_burst(BASE + 64'h18, 4'h7, 3, 3, 2, 0, 0, "t3_wrap");

        // Narrow beats, FIXED bursts with merged strobes, WRAP write
        rd_burst(BASE + 64'h20, 4'h4, 3, 2, 1, 0, 0, "narrow");
        wr_burst(BASE + 64'h40, 4'h6, 3, 3, 0, 1, 0, 0, 64'd0, "fixed_wr");
        rd_burst(BASE + 64'h40, 4'h6, 2, 3, 0, 0, 0, "fixed_rd");
        wr_burst(BASE + 64'h38, 4'h8, 7, 3, 2, 1, 0, 0, 64'd0, "wrap_wr");
        rd_burst(BASE + 64'h30, 4'h9, 7, 3, 1, 0, 0, "wrap_chk");

        // Randomized INCR/WRAP traffic inside the filled region
        for (int k = 0; k < 6; k++) begin
            id = 4'($urandom);
            burst = $urandom_range(1, 2);
            if (burst == 1) begin
                len = $urandom_range(0, 7);
                a   = BASE + 64'(8 * $urandom_range(0, 24));
            end else begin
                len = (1 << $urandom_range(1, 3)) - 1;
                a   = BASE + 64'(8 * $urandom_range(0, 31));
            end
            wr_burst(a, id, len, 3, burst, 1, 0, 0, 64'd0, "rnd_wr");
            burst = $urandom_range(1, 2);
            if (burst == 1) begin
                len = $urandom_range(0, 7);
                a   = BASE + 64'(8 * $urandom_range(0, 24));
            end else begin
                len = (1 << $urandom_range(1, 3)) - 1;
                a   = BASE + 64'(8 * $urandom_range(0, 31));
            end
            rd_burst(a, 4'($urandom), len, 3, burst, $urandom_range(0, 1), 0, "rnd_rd");
        end

        // Read latency 3 with r_ready toggling
        sel = 1'b1;
        rd_burst(BASE + 64'h20, 4'hC, 3, 3, 1, 1, 3, "t4_lat3");
        rd_burst(BASE + 64'h08, 4'hD, 0, 3, 1, 0, 3, "t4_lat3_single");
        sel = 1'b0;

        // SLVERR cases
        wr_burst(BASE + 64'h60, 4'hE, 1, 3, 1, 0, 1, 0, 64'd0, "t5_early_last");
        rd_burst(BASE + 64'h48, 4'hB, 2, 3, 3, 0, 0, "t5_burst11");
        rd_burst(BASE + 64'h10, 4'h2, 2, 3, 2, 0, 0, "bad_wrap_len");
        rd_burst(BASE, 4'h3, 1, 4, 1, 0, 0, "bad_size");

        // Reset during beat 2 of a len7 read
        ar_addr = BASE; ar_id = 4'h6; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'd1;
        ar_valid = 1'b1; r_ready = 1'b1;
        step();
        ar_valid = 1'b0;
        step();
        step();
        check("t6.beat2_valid", 64'(r_valid_o), 64'd1);
        check("t6.beat2_data", r_data_o, model_mem[BASE + 64'h10]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6.r_valid", 64'(r_valid_o), 64'd0);
        check("t6.ar_ready", 64'(ar_ready_o), 64'd1);
        check("t6.aw_ready", 64'(aw_ready_o), 64'd1);
        check("t6.r_last", 64'(r_last_o), 64'd0);
        rd_burst(BASE + 64'h28, 4'h1, 1, 3, 1, 0, 0, "t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
